// File: rtl/vend_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_sequencer: issues product / dime / nickel actuator commands with a    |
// | four-phase ack. Optional ack timeout enabled by defining VEND_TIMEOUT_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vend_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_dispense,
  input  logic [2:0] req_change,
  input  logic       act_ack,
  output logic       act_product,
  output logic       act_dime,
  output logic       act_nickel,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROD   = 3'd1,
    S_DIME   = 3'd2,
    S_NICKEL = 3'd3,
    S_REL    = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] remaining, remaining_nxt;
  logic       flag, flag_nxt;
  logic       done_nxt;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit timeout counter (1..255)");
  end

  // Next command from the outstanding work; S_IDLE means the sequence is finished.
  function automatic state_t pick(input logic f, input logic [2:0] r);
    if (f)              return S_PROD;
    else if (r >= 3'd2) return S_DIME;
    else if (r == 3'd1) return S_NICKEL;
    else                return S_IDLE;
  endfunction

`ifdef VEND_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
  logic       in_wait, nxt_wait;

  assign in_wait  = (state == S_PROD) || (state == S_DIME) ||
                    (state == S_NICKEL) || (state == S_REL);
  assign nxt_wait = (state_nxt == S_PROD) || (state_nxt == S_DIME) ||
                    (state_nxt == S_NICKEL) || (state_nxt == S_REL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 tmo_cnt <= '0;
    else if (nxt_wait && state_nxt != state) tmo_cnt <= '0;
    else if (in_wait)                        tmo_cnt <= tmo_cnt + 8'd1;
  end
`endif

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    flag_nxt      = flag;
    done_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          flag_nxt      = req_dispense;
          remaining_nxt = req_change;
          if (req_change > 3'd4) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt = pick(req_dispense, req_change);
            done_nxt  = (pick(req_dispense, req_change) == S_IDLE);
          end
        end
      end
      S_PROD: begin
        if (act_ack) begin
          flag_nxt  = 1'b0;
          state_nxt = S_REL;
        end
      end
      S_DIME: begin
        if (act_ack) begin
          remaining_nxt = remaining - 3'd2;
          state_nxt     = S_REL;
        end
      end
      S_NICKEL: begin
        if (act_ack) begin
          remaining_nxt = remaining - 3'd1;
          state_nxt     = S_REL;
        end
      end
      S_REL: begin
        if (!act_ack) begin
          state_nxt = pick(flag, remaining);
          done_nxt  = (pick(flag, remaining) == S_IDLE);
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
`ifdef VEND_TIMEOUT_EN
    if (in_wait && tmo_cnt == TMO_LAST) begin
      state_nxt = S_FAULT;
      done_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= 3'd0;
      flag      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      flag      <= flag_nxt;
      done      <= done_nxt;
    end
  end

  // Moore outputs: commands drop the cycle after ack is sampled because the state has moved to REL.
  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign fault       = (state == S_FAULT);
  assign act_product = (state == S_PROD);
  assign act_dime    = (state == S_DIME);
  assign act_nickel  = (state == S_NICKEL);

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// Directed testbench for vend_sequencer; outputs are sampled and inputs driven on the falling edge.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_dispense;
  logic [2:0] req_change;
  logic       act_ack, act_product, act_dime, act_nickel;
  logic       busy, done, fault;
  logic [6:0] outs;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  vend_sequencer #(.TIMEOUT_CYCLES(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dispense(req_dispense),
    .req_change  (req_change),
    .act_ack     (act_ack),
    .act_product (act_product),
    .act_dime    (act_dime),
    .act_nickel  (act_nickel),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  // {ready, busy, done, fault, product, dime, nickel}
  assign outs = {req_ready, busy, done, fault, act_product, act_dime, act_nickel};

  // Presents a request for one cycle, then scrambles the inputs; returns on the cycle after acceptance.
  task automatic request(input logic d, input logic [2:0] c);
    @(negedge clk);
    req_valid = 1'b1; req_dispense = d; req_change = c;
    @(negedge clk);
    req_valid = 1'b0; req_dispense = ~d; req_change = ~c;
  endtask

  // Prompt ack responder; records command order (1=product 2=dime 3=nickel) until done.
  task automatic run_seq(output logic [15:0] seq, output int ncmd, output int ndone,
                         output int overlap);
    logic [2:0] prev, cur;
    prev = 3'b000; seq = '0; ncmd = 0; ndone = 0; overlap = 0;
    for (int i = 0; i < 200 && ndone == 0; i++) begin
      if (i > 0) @(negedge clk);
      cur = {act_product, act_dime, act_nickel};
      if (cur != 3'b000 && cur != 3'b100 && cur != 3'b010 && cur != 3'b001) overlap++;
      if (cur != 3'b000 && prev == 3'b000 && ncmd < 8) begin
        seq[2*ncmd +: 2] = cur[2] ? 2'd1 : (cur[1] ? 2'd2 : 2'd3);
        ncmd++;
      end
      if (done) ndone++;
      act_ack = (cur != 3'b000);
      prev = cur;
    end
    @(negedge clk);
    if (done) ndone++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_dispense = 1'b0; req_change = 3'd0; act_ack = 1'b0;
    #3;
    total++;
    if (outs !== 7'b1000000) begin bad++; $display("FAIL reset_async: got %b want %b", outs, 7'b1000000); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== 7'b1000000) begin bad++; $display("FAIL reset_idle: got %b want %b", outs, 7'b1000000); end
  endtask

  task automatic test_sequences();
    logic        d_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  c_t [4] = '{3'd3, 3'd4, 3'd2, 3'd1};
    logic [15:0] s_t [4] = '{16'd57, 16'd10, 16'd9, 16'd3};
    int          n_t [4] = '{3, 2, 2, 1};
    logic [15:0] seq;
    int ncmd, ndone, overlap;
    for (int k = 0; k < 4; k++) begin
      request(d_t[k], c_t[k]);
      total++;
      if ({req_ready, busy} !== 2'b01) begin
        bad++; $display("FAIL seq%0d_accept: got ready/busy %b want 01", k, {req_ready, busy});
      end
      run_seq(seq, ncmd, ndone, overlap);
      total++;
      if (seq !== s_t[k] || ncmd != n_t[k]) begin
        bad++; $display("FAIL seq%0d_order: got seq=%0d n=%0d want seq=%0d n=%0d", k, seq, ncmd, s_t[k], n_t[k]);
      end
      total++;
      if (ndone != 1 || overlap != 0) begin
        bad++; $display("FAIL seq%0d_done: got done=%0d overlap=%0d want 1 0", k, ndone, overlap);
      end
      total++;
      if (outs !== 7'b1000000) begin bad++; $display("FAIL seq%0d_end: got %b want %b", k, outs, 7'b1000000); end
    end
  endtask

  task automatic test_zero();
    request(1'b0, 3'd0);
    total++;
    if (outs !== 7'b1010000) begin bad++; $display("FAIL zero_done: got %b want %b", outs, 7'b1010000); end
    @(negedge clk);
    total++;
    if (outs !== 7'b1000000) begin bad++; $display("FAIL zero_after: got %b want %b", outs, 7'b1000000); end
  endtask

  task automatic test_fault();
    request(1'b1, 3'd6);
    total++;
    if (outs !== 7'b0101000) begin bad++; $display("FAIL fault_enter: got %b want %b", outs, 7'b0101000); end
    req_valid = 1'b1; req_dispense = 1'b1; req_change = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (outs !== 7'b0101000) begin bad++; $display("FAIL fault_hold%0d: got %b want %b", i, outs, 7'b0101000); end
    end
    req_valid = 1'b0;
    rst = 1'b1; #1;
    total++;
    if (outs !== 7'b1000000) begin bad++; $display("FAIL fault_clear: got %b want %b", outs, 7'b1000000); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    act_ack = 1'b0;
    request(1'b1, 3'd0);
    n = 0;
    while (act_product && n < 300) begin
      n++;
      @(negedge clk);
    end
`ifdef VEND_TIMEOUT_EN
    total++;
    if (n != 10) begin bad++; $display("FAIL stall_len: got %0d want %0d", n, 10); end
    total++;
    if (outs !== 7'b0101000) begin bad++; $display("FAIL stall_fault: got %b want %b", outs, 7'b0101000); end
`else
    total++;
    if (n != 300) begin bad++; $display("FAIL stall_len: got %0d want %0d", n, 300); end
    total++;
    if (outs !== 7'b0100100) begin bad++; $display("FAIL stall_hold: got %b want %b", outs, 7'b0100100); end
`endif
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] seq;
    int ncmd, ndone, overlap;
    act_ack = 1'b0;
    request(1'b0, 3'd2);
    total++;
    if (outs !== 7'b0100010) begin bad++; $display("FAIL ares_dime: got %b want %b", outs, 7'b0100010); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs !== 7'b1000000) begin bad++; $display("FAIL ares_now: got %b want %b", outs, 7'b1000000); end
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    request(1'b1, 3'd0);
    run_seq(seq, ncmd, ndone, overlap);
    total++;
    if (seq !== 16'd1 || ncmd != 1 || ndone != 1) begin
      bad++; $display("FAIL ares_again: got seq=%0d n=%0d done=%0d want 1 1 1", seq, ncmd, ndone);
    end
  endtask

  task automatic test_ack_stuck();
    act_ack = 1'b1;
    request(1'b1, 3'd0);
    total++;
    if (outs !== 7'b0100100) begin bad++; $display("FAIL stuck_cmd: got %b want %b", outs, 7'b0100100); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (outs !== 7'b0100000) begin bad++; $display("FAIL stuck_rel%0d: got %b want %b", i, outs, 7'b0100000); end
    end
    act_ack = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== 7'b1010000) begin bad++; $display("FAIL stuck_done: got %b want %b", outs, 7'b1010000); end
    @(negedge clk);
    total++;
    if (outs !== 7'b1000000) begin bad++; $display("FAIL stuck_after: got %b want %b", outs, 7'b1000000); end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_zero();
    test_fault();
    test_stall();
    test_async_reset();
    test_ack_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles an actuator command waits for act_ack (8-bit counter).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  vend request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_dispense  input  1  release one product.
REQ-007 req_change  input  3  change owed in nickel units (legal 0-4).
REQ-008 act_ack  input  1  actuator acknowledge, four-phase.
REQ-009 act_product  output  1  product-release command level.
REQ-010 act_dime  output  1  dime-eject command level.
REQ-011 act_nickel  output  1  nickel-eject command level.
REQ-012 busy  output  1  a sequence is in progress.
REQ-013 done  output  1  one-cycle pulse when a sequence completes.
REQ-014 fault  output  1  sticky error flag.

Function
REQ-015 States SHALL be IDLE, PROD, DIME, NICKEL, REL (ack-release wait), FAULT.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-017 On acceptance, req_dispense and req_change SHALL be latched into a flag and a 3-bit remaining register; later input changes SHALL be ignored.
REQ-018 The first command SHALL assert on the cycle after acceptance.
REQ-019 Order SHALL be: product if flag set; then DIME while remaining >= 2, subtracting 2 each; then NICKEL if remaining == 1, subtracting 1.
REQ-020 At most one act_* output SHALL be 1 in any cycle.
REQ-021 In PROD, DIME, or NICKEL, the command SHALL hold high until act_ack is sampled 1; it SHALL drop on the next cycle, and the FSM SHALL enter REL.
REQ-022 REL SHALL wait until act_ack is sampled 0, then select the next command per REQ-019 on the following cycle, or finish.
REQ-023 Finish SHALL pulse done for exactly one cycle and return to IDLE in that same cycle.
REQ-024 A request with req_dispense=0 and req_change=0 SHALL complete with done on the cycle after acceptance, with no command issued.
REQ-025 A request with req_change 5-7 SHALL be accepted, issue no command, and enter FAULT on the next cycle.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 FAULT SHALL hold fault=1, req_ready=0, and all act_* at 0 until rst; done SHALL NOT pulse.
REQ-028 If act_ack is already 1 when a command asserts, it SHALL count as the acknowledge.

Reset
REQ-029 rst SHALL immediately force IDLE, remaining=0, flag=0, timeout counter=0, and all outputs 0 except req_ready=1.
REQ-030 rst asserted mid-sequence SHALL abandon the sequence, with no done pulse and no further commands.

Configuration
REQ-031 With VEND_TIMEOUT_EN defined:
- A counter SHALL clear on every command assertion and on every REL entry.
- It SHALL increment each cycle spent in PROD, DIME, NICKEL, or REL.
- Reaching TIMEOUT_CYCLES SHALL force FAULT on the next cycle.
REQ-032 Without VEND_TIMEOUT_EN, no counter SHALL exist, waits SHALL be unbounded, and REQ-025 SHALL be the only fault source.

Verification
REQ-033 Dispense=1, change=3, prompt acks -> act_product, then act_dime, then act_nickel, each one handshake; done pulses once; busy returns 0.
REQ-034 Dispense=0, change=4 -> exactly two act_dime handshakes, no act_nickel, then done.
REQ-035 Change=6 -> accepted, no act_* activity, fault=1 next cycle, req_ready=0 until rst.
REQ-036 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=10, act_ack held 0 -> act_product high for 10 cycles, then FAULT with act_product=0; without the macro it stays high indefinitely.
REQ-037 rst pulsed while act_dime is high -> all outputs 0 and req_ready=1 asynchronously; a new dispense=1, change=0 request then completes normally.
REQ-038 act_ack stuck 1 from before acceptance -> act_product high for 1 cycle, REL held until ack falls, then done.
